// File: rtl/bram_mw_loader_if.sv
// Stream-side and RAM-side signal bundle for bram_mw_loader.
// master: the loader itself; slave: stream source, RAM and row consumer.
interface bram_mw_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_WORDS  = 9
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;

    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [AW-1:0]         ram_wr_addr;
    logic [NUM_WORDS-1:0]  ram_wr_en;
    logic [AW-1:0]         ram_rd_addr;
    logic                  ram_rd_en;

    logic                  out_valid;
    logic [AW-1:0]         out_addr;

    modport master (
        input  in_data, in_valid, in_last,
        output in_ready,
        output ram_wr_data, ram_wr_addr, ram_wr_en, ram_rd_addr, ram_rd_en,
        output out_valid, out_addr
    );

    modport slave (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  ram_wr_data, ram_wr_addr, ram_wr_en, ram_rd_addr, ram_rd_en,
        input  out_valid, out_addr
    );
endinterface

// File: rtl/bram_mw_loader.sv
// Load/scan sequencer for block_ram_multi_word: fills rows word-by-word from a stream, then scans rows.
// Optional stream framing check on in_last is enabled with `define BRAM_MW_LOADER_LAST_CHECK_EN.
module bram_mw_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_WORDS  = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic scan,
    output logic busy,
    output logic done,
    output logic err,
    bram_mw_loader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(NUM_WORDS);
    localparam logic [AW-1:0] ROW_LAST  = AW'(DEPTH - 1);
    localparam logic [WW-1:0] WIDX_LAST = WW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;

    state_t                state;
    logic [WW-1:0]         widx;
    logic [AW-1:0]         row;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [AW-1:0]         pipe_addr [RD_LATENCY];
    logic                  pre_valid;
    logic [AW-1:0]         pre_addr;
    logic                  handshake;
    logic                  final_word;

    // busy also covers the done cycle, where the FSM has already returned to IDLE
    assign bus.in_ready = (state == LOAD);
    assign busy         = (state != IDLE) || done;
    assign handshake    = bus.in_ready && bus.in_valid;
    assign final_word   = (row == ROW_LAST) && (widx == WIDX_LAST);

    assign bus.out_valid = pipe_valid[RD_LATENCY-1];
    assign bus.out_addr  = pipe_addr[RD_LATENCY-1];

    // pre_* is the read beat that becomes out_valid on the next cycle
    generate
        if (RD_LATENCY == 1) begin : g_pre_direct
            assign pre_valid = bus.ram_rd_en;
            assign pre_addr  = bus.ram_rd_addr;
        end else begin : g_pre_pipe
            assign pre_valid = pipe_valid[RD_LATENCY-2];
            assign pre_addr  = pipe_addr[RD_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_addr[i] <= '0;
        end else begin
            pipe_valid[0] <= bus.ram_rd_en;
            pipe_addr[0]  <= bus.ram_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

`ifndef BRAM_MW_LOADER_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = bus.in_last;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            widx            <= '0;
            row             <= '0;
            done            <= 1'b0;
            bus.ram_wr_data <= '0;
            bus.ram_wr_addr <= '0;
            bus.ram_wr_en   <= '0;
            bus.ram_rd_addr <= '0;
            bus.ram_rd_en   <= 1'b0;
`ifdef BRAM_MW_LOADER_LAST_CHECK_EN
            err             <= 1'b0;
`endif
        end else begin
            done          <= 1'b0;
            bus.ram_wr_en <= '0;
            bus.ram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        widx  <= '0;
                        row   <= '0;
`ifdef BRAM_MW_LOADER_LAST_CHECK_EN
                        err   <= 1'b0;
`endif
                    end else if (scan) begin
                        // row 0 is issued straight from IDLE so reads start the cycle after scan
                        state           <= SCAN;
                        bus.ram_rd_en   <= 1'b1;
                        bus.ram_rd_addr <= '0;
                        row             <= AW'(1);
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        bus.ram_wr_data <= bus.in_data;
                        bus.ram_wr_addr <= row;
                        bus.ram_wr_en   <= NUM_WORDS'(1) << widx;
`ifdef BRAM_MW_LOADER_LAST_CHECK_EN
                        if (bus.in_last != final_word) err <= 1'b1;
`endif
                        if (final_word) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            widx  <= '0;
                            row   <= '0;
                        end else if (widx == WIDX_LAST) begin
                            widx <= '0;
                            row  <= row + 1'b1;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    bus.ram_rd_en   <= 1'b1;
                    bus.ram_rd_addr <= row;
                    if (row == ROW_LAST) begin
                        state <= DRAIN;
                        row   <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DRAIN: begin
                    if (pre_valid && (pre_addr == ROW_LAST)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_mw_loader.sv
// Directed bench for bram_mw_loader: two instances (RD_LATENCY 1 and 2) share one stimulus,
// each backed by a behavioural multi-word RAM model.
module tb_bram_mw_loader;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NW    = 9;
    localparam int AW    = 2;
    localparam int PASS  = DEPTH * NW;
`ifdef BRAM_MW_LOADER_LAST_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, scan, in_valid, in_last, clr_req;
    logic [DW-1:0] in_data;
    logic busy1, done1, err1, busy2, done2, err2;

    int n_checks = 0;
    int n_errors = 0;

    int cyc, wr_cnt, nonhot, seq_err, final_cyc, hs_done;
    int first_wr_en, first_wr_addr, first_wr_data;
    int rd_cnt1, rd_cnt2, done_cnt1, done_cnt2, done_cyc1, done_cyc2;
    int beats1, beats2, first_beat1, first_beat2, last_beat1, last_beat2;
    int addr_err1, addr_err2, w8_1, w8_2, r3w0_1;

    bram_mw_loader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus1 ();
    bram_mw_loader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus2 ();

    assign bus1.in_data  = in_data;
    assign bus1.in_valid = in_valid;
    assign bus1.in_last  = in_last;
    assign bus2.in_data  = in_data;
    assign bus2.in_valid = in_valid;
    assign bus2.in_last  = in_last;

    bram_mw_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .scan(scan),
        .busy(busy1), .done(done1), .err(err1), .bus(bus1)
    );

    bram_mw_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .scan(scan),
        .busy(busy2), .done(done2), .err(err2), .bus(bus2)
    );

    always #5 clk = ~clk;

    logic [NW*DW-1:0] mem1 [DEPTH];
    logic [NW*DW-1:0] mem2 [DEPTH];
    logic [NW*DW-1:0] q1, q2a, q2b;

    // RAM models; the second one has an output register (two-cycle read)
    always @(posedge clk) begin
        if (clr_req) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem1[r] <= '1;
                mem2[r] <= '1;
            end
        end
        for (int w = 0; w < NW; w++) begin
            if (bus1.ram_wr_en[w]) mem1[bus1.ram_wr_addr][w*DW +: DW] <= bus1.ram_wr_data;
            if (bus2.ram_wr_en[w]) mem2[bus2.ram_wr_addr][w*DW +: DW] <= bus2.ram_wr_data;
        end
        if (bus1.ram_rd_en) q1  <= mem1[bus1.ram_rd_addr];
        if (bus2.ram_rd_en) q2a <= mem2[bus2.ram_rd_addr];
        q2b <= q2a;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        wr_cnt = 0; nonhot = 0; seq_err = 0;
        first_wr_en = -1; first_wr_addr = -1; first_wr_data = -1;
        rd_cnt1 = 0; rd_cnt2 = 0; done_cnt1 = 0; done_cnt2 = 0; done_cyc1 = -1; done_cyc2 = -1;
        beats1 = 0; beats2 = 0; first_beat1 = -1; first_beat2 = -1; last_beat1 = -1; last_beat2 = -1;
        addr_err1 = 0; addr_err2 = 0; w8_1 = -1; w8_2 = -1; r3w0_1 = -1;
    endtask

    // Advance to the next falling edge and log what both instances present in that cycle
    task automatic tick();
        logic [NW-1:0] exp_en;
        @(negedge clk);
        cyc++;
        if (bus1.ram_wr_en != '0) begin
            if ($countones(bus1.ram_wr_en) != 1) nonhot++;
            exp_en = NW'(1) << (wr_cnt % NW);
            if (wr_cnt == 0) begin
                first_wr_en   = int'(bus1.ram_wr_en);
                first_wr_addr = int'(bus1.ram_wr_addr);
                first_wr_data = int'(bus1.ram_wr_data);
            end
            if (bus1.ram_wr_en !== exp_en || bus1.ram_wr_addr !== AW'(wr_cnt / NW) ||
                bus1.ram_wr_data !== DW'(wr_cnt)) seq_err++;
            wr_cnt++;
        end
        if (bus1.ram_rd_en) rd_cnt1++;
        if (bus2.ram_rd_en) rd_cnt2++;
        if (done1) begin done_cnt1++; done_cyc1 = cyc; end
        if (done2) begin done_cnt2++; done_cyc2 = cyc; end
        if (bus1.out_valid) begin
            if (beats1 == 0) first_beat1 = cyc;
            last_beat1 = cyc;
            if (bus1.out_addr !== AW'(beats1)) addr_err1++;
            if (bus1.out_addr == 2'd0) w8_1 = int'(q1[8*DW +: DW]);
            if (bus1.out_addr == 2'd3) r3w0_1 = int'(q1[DW-1:0]);
            beats1++;
        end
        if (bus2.out_valid) begin
            if (beats2 == 0) first_beat2 = cyc;
            last_beat2 = cyc;
            if (bus2.out_addr !== AW'(beats2)) addr_err2++;
            if (bus2.out_addr == 2'd0) w8_2 = int'(q2b[8*DW +: DW]);
            beats2++;
        end
    endtask

    function automatic int memErrors();
        int e = 0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int w = 0; w < NW; w++) begin
                if (mem1[r][w*DW +: DW] !== DW'(NW*r + w)) e++;
                if (mem2[r][w*DW +: DW] !== DW'(NW*r + w)) e++;
            end
        end
        return e;
    endfunction

    task automatic clearMem();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    // One load pass of words 0..k; optional gaps, misplaced in_last, scan held, early abort
    task automatic applyStimulus(input bit gap, input int last_pos, input bit with_scan, input int abort_after);
        int k = 0;
        int iter = 0;
        bit v, hs;
        start = 1'b1;
        scan  = with_scan;
        tick();
        start = 1'b0;
        checkOutput("in_ready_after_start", bus1.in_ready, 1);
        checkOutput("err_clear_on_start", err1, 0);
        while (k < PASS && iter < 200) begin
            v  = gap ? (iter % 3 != 2) : 1'b1;
            hs = v && bus1.in_ready;
            in_valid = v;
            in_data  = DW'(k);
            in_last  = (k == last_pos);
            if (hs && k == PASS - 1) final_cyc = cyc;
            if (hs && k == last_pos && last_pos != PASS - 1) checkOutput("err_before_bad_last", err1, 0);
            tick();
            iter++;
            if (hs) begin
                if (k == last_pos && last_pos != PASS - 1) checkOutput("err_after_bad_last", err1, EXP_ERR);
                k++;
                if (k == abort_after) break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        scan     = 1'b0;
        if (iter >= 200) checkOutput("load_timeout_iters", iter, 0);
        hs_done = k;
    endtask

    task automatic checkLoad(input string tag);
        checkOutput({tag, "_done_now"}, done1, 1);
        checkOutput({tag, "_busy_at_done"}, busy1, 1);
        checkOutput({tag, "_ready_low"}, bus1.in_ready, 0);
        tick();
        checkOutput({tag, "_done_cycle"}, done_cyc1, final_cyc + 1);
        checkOutput({tag, "_done_count"}, done_cnt1, 1);
        checkOutput({tag, "_writes"}, wr_cnt, PASS);
        checkOutput({tag, "_seq_err"}, seq_err, 0);
        checkOutput({tag, "_nonhot"}, nonhot, 0);
        checkOutput({tag, "_mem"}, memErrors(), 0);
        checkOutput({tag, "_busy_after"}, busy1, 0);
    endtask

    task automatic runScan(input string tag);
        int t0;
        clearMon();
        scan = 1'b1;
        t0 = cyc;
        tick();
        scan = 1'b0;
        repeat (10) tick();
        checkOutput({tag, "_rd_en_l1"}, rd_cnt1, DEPTH);
        checkOutput({tag, "_beats_l1"}, beats1, DEPTH);
        checkOutput({tag, "_first_l1"}, first_beat1, t0 + 2);
        checkOutput({tag, "_last_l1"}, last_beat1, t0 + 5);
        checkOutput({tag, "_addr_l1"}, addr_err1, 0);
        checkOutput({tag, "_done_l1"}, done_cyc1, t0 + 5);
        checkOutput({tag, "_row0w8_l1"}, w8_1, 8);
        checkOutput({tag, "_row3w0_l1"}, r3w0_1, 27);
        checkOutput({tag, "_beats_l2"}, beats2, DEPTH);
        checkOutput({tag, "_first_l2"}, first_beat2, t0 + 3);
        checkOutput({tag, "_last_l2"}, last_beat2, t0 + 6);
        checkOutput({tag, "_addr_l2"}, addr_err2, 0);
        checkOutput({tag, "_done_l2"}, done_cyc2, t0 + 6);
        checkOutput({tag, "_row0w8_l2"}, w8_2, 8);
        checkOutput({tag, "_idle_after"}, busy1 | busy2, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; scan = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; clr_req = 1'b0; cyc = 0; final_cyc = -1; hs_done = 0;
        clearMon();
        #1;
        checkOutput("rst_busy", {busy1, busy2}, 0);
        checkOutput("rst_done_err", {done1, done2, err1, err2}, 0);
        checkOutput("rst_ready", {bus1.in_ready, bus2.in_ready}, 0);
        checkOutput("rst_wr", {bus1.ram_wr_en, bus1.ram_wr_data, 6'(bus1.ram_wr_addr)}, 0);
        checkOutput("rst_rd", {bus1.ram_rd_en, bus1.ram_rd_addr, bus1.out_valid, bus1.out_addr}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] back-to-back load");
        clearMem(); clearMon();
        applyStimulus(1'b0, PASS - 1, 1'b0, 0);
        checkLoad("load");
        checkOutput("load_err", err1, 0);

        $display("[TB] scan after load");
        runScan("scan");

        $display("[TB] gapped load");
        clearMem(); clearMon();
        applyStimulus(1'b1, PASS - 1, 1'b0, 0);
        checkLoad("gap");
        runScan("scan_gap");

        $display("[TB] start and scan together, scan held during load");
        clearMem(); clearMon();
        applyStimulus(1'b0, PASS - 1, 1'b1, 0);
        checkLoad("prio");
        checkOutput("prio_no_rd_l1", rd_cnt1, 0);
        checkOutput("prio_no_rd_l2", rd_cnt2, 0);

        $display("[TB] reset after 20 handshakes");
        clearMon();
        applyStimulus(1'b0, PASS - 1, 1'b0, 20);
        checkOutput("abort_hs", hs_done, 20);
        checkOutput("abort_wr_pending", int'(bus1.ram_wr_data), 19);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {busy1, busy2, done1, done2}, 0);
        checkOutput("abort_ready", bus1.in_ready, 0);
        checkOutput("abort_wr", {bus1.ram_wr_en, bus1.ram_wr_data, 6'(bus1.ram_wr_addr)}, 0);
        checkOutput("abort_rd", {bus1.ram_rd_en, bus1.out_valid, bus2.out_valid}, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("abort_no_done", done_cnt1 + done_cnt2, 0);
        clearMem(); clearMon();
        applyStimulus(1'b0, PASS - 1, 1'b0, 0);
        checkOutput("reload_first_en", first_wr_en, 1);
        checkOutput("reload_first_addr", first_wr_addr, 0);
        checkOutput("reload_first_data", first_wr_data, 0);
        checkLoad("reload");

        $display("[TB] in_last on handshake 10");
        clearMem(); clearMon();
        applyStimulus(1'b0, 9, 1'b0, 0);
        checkOutput("badlast_err_sticky", err1, EXP_ERR);
        checkOutput("badlast_err_l2", err2, EXP_ERR);
        checkLoad("badlast");
        clearMon();
        applyStimulus(1'b0, PASS - 1, 1'b0, 0);
        checkLoad("after_badlast");
        checkOutput("after_badlast_err", err1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
